rr_queue_arbiter: RTL and testbench

Sequential round-robin arbiter that picks which scheduling queue may transmit next and holds that grant until the downstream transmit stage reports completion. It consumes a per-queue non-empty vector and maintains the current-queue pointer. It performs the cyclic "next valid after current" search each arbitration round. A queue may send up to BURST packets per turn before the pointer advances. The arbiter sits between the queue-status logic and the packet transmit mux.

---
 rtl/rr_queue_arbiter.sv | 129 ++++++++++++
 tb/tb_rr_queue_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_queue_arbiter.sv
// rr_queue_arbiter
//   Round-robin arbiter between the queue-status logic and the packet
//   transmit mux. Each turn it offers one queue to the transmit stage, holds
//   the grant while the packet is in flight, and lets a queue send up to
//   BURST packets before the pointer moves on.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   queue_valid  per-queue non-empty flags
//   grant_valid  grant offered downstream (OFFER state)
//   grant_index  queue being offered or served
//   grant_ready  downstream accepts the offered grant
//   pkt_done     one-cycle pulse at the last beat of the granted packet
//   busy         packet from grant_index in flight (BUSY state)
module rr_queue_arbiter #(
    parameter int QUEUE_COUNT = 3,
    parameter int SEL_WIDTH   = $clog2(QUEUE_COUNT),
    parameter int BURST       = 1,
    parameter int CNT_WIDTH   = $clog2(BURST + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [QUEUE_COUNT-1:0] queue_valid,
    output logic                   grant_valid,
    output logic [SEL_WIDTH-1:0]   grant_index,
    input  logic                   grant_ready,
    input  logic                   pkt_done,
    output logic                   busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_OFFER = 2'd1,
        S_BUSY  = 2'd2
    } state_t;

    state_t                 state, state_nxt;
    logic [SEL_WIDTH-1:0]   curr_ptr;
    logic [CNT_WIDTH-1:0]   burst_cnt;
    logic [SEL_WIDTH-1:0]   next_idx;
    logic                   found;
    logic                   sel_valid;
    logic                   burst_more;
    logic [CNT_WIDTH:0]     cnt_inc;

    // (base + k) mod QUEUE_COUNT for 1 <= k <= QUEUE_COUNT; base is always a
    // legal index, so a single conditional subtract performs the wrap.
    function automatic logic [SEL_WIDTH-1:0] idx_at(input logic [SEL_WIDTH-1:0] base,
                                                    input int k);
        int s;
        s = int'(base) + k;
        if (s >= QUEUE_COUNT) s = s - QUEUE_COUNT;
        return SEL_WIDTH'(s);
    endfunction

    // Cyclic search starting after curr_ptr. Walking the offsets from the
    // far end down means the last hit assigned is the nearest one, which
    // gives a plain priority mux; curr_ptr itself (offset QUEUE_COUNT) has
    // the lowest priority.
    always_comb begin
        next_idx = curr_ptr;
        for (int k = QUEUE_COUNT; k >= 1; k--) begin
            if (queue_valid[idx_at(curr_ptr, k)]) next_idx = idx_at(curr_ptr, k);
        end
    end

    assign found     = |queue_valid;
    assign sel_valid = queue_valid[grant_index];
    assign cnt_inc   = {1'b0, burst_cnt} + (CNT_WIDTH + 1)'(1);
    // Another packet is allowed this turn only if the count after this
    // completion is still below BURST and the queue still has data.
    assign burst_more = (cnt_inc < (CNT_WIDTH + 1)'(BURST)) && sel_valid;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (found) state_nxt = S_OFFER;
            S_OFFER: begin
                // A drained queue withdraws the offer even if ready is high.
                if (!sel_valid)       state_nxt = S_IDLE;
                else if (grant_ready) state_nxt = S_BUSY;
            end
            S_BUSY:  if (pkt_done) state_nxt = burst_more ? S_OFFER : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs are pure decodes of the state register.
    always_comb begin
        grant_valid = (state == S_OFFER);
        busy        = (state == S_BUSY);
    end

    // Datapath: selected queue, round-robin pointer, burst counter.
    // curr_ptr only moves when a turn really ends, so a withdrawn offer
    // leaves the rotation where it was.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_index <= '0;
            curr_ptr    <= SEL_WIDTH'(QUEUE_COUNT - 1);
            burst_cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (found) begin
                        grant_index <= next_idx;
                        burst_cnt   <= '0;
                    end
                end
                S_BUSY: begin
                    if (pkt_done) begin
                        if (int'(burst_cnt) < BURST) burst_cnt <= cnt_inc[CNT_WIDTH-1:0];
                        if (!burst_more)             curr_ptr  <= grant_index;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_queue_arbiter.sv
// Bench for rr_queue_arbiter: two instances (BURST=1 and BURST=3) share the
// same stimulus; a turn-level reference model per instance is compared every
// cycle, and directed sequences pin the model with hand-derived grant orders.
module tb_rr_queue_arbiter;
    localparam int QC = 3;

    logic          clk;
    logic          rst_n;
    logic [QC-1:0] queue_valid;
    logic          grant_ready;
    logic          pkt_done;
    logic          gv1, by1, gv3, by3;
    logic [1:0]    gi1, gi3;

    int vectors     = 0;
    int miscompares = 0;

    rr_queue_arbiter #(.QUEUE_COUNT(QC), .BURST(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .queue_valid(queue_valid),
        .grant_valid(gv1), .grant_index(gi1), .grant_ready(grant_ready),
        .pkt_done(pkt_done), .busy(by1)
    );

    rr_queue_arbiter #(.QUEUE_COUNT(QC), .BURST(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .queue_valid(queue_valid),
        .grant_valid(gv3), .grant_index(gi3), .grant_ready(grant_ready),
        .pkt_done(pkt_done), .busy(by3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // phase: 0 waiting for a queue, 1 offering, 2 packet in flight
    typedef struct {
        int phase;
        int idx;
        int last;
        int sent;
    } mdl_t;

    localparam mdl_t MDL_RST = '{phase: 0, idx: 0, last: QC - 1, sent: 0};

    mdl_t m1 = MDL_RST;
    mdl_t m3 = MDL_RST;

    function automatic int rr_pick(input int last, input logic [QC-1:0] v);
        for (int k = 1; k <= QC; k++) begin
            int j;
            j = (last + k) % QC;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    function automatic mdl_t mdl_step(input mdl_t m, input int burst, input logic [QC-1:0] v,
                                      input logic rdy, input logic done);
        mdl_t r;
        int   j;
        r = m;
        if (m.phase == 0) begin
            j = rr_pick(m.last, v);
            if (j >= 0) begin
                r.phase = 1; r.idx = j; r.sent = 0;
            end
        end else if (m.phase == 1) begin
            if (!v[m.idx])  r.phase = 0;
            else if (rdy)   r.phase = 2;
        end else if (done) begin
            r.sent = (m.sent + 1 > burst) ? burst : m.sent + 1;
            if (r.sent < burst && v[m.idx]) r.phase = 1;
            else begin
                r.phase = 0; r.last = m.idx;
            end
        end
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m1 <= MDL_RST;
            m3 <= MDL_RST;
        end else begin
            m1 <= mdl_step(m1, 1, queue_valid, grant_ready, pkt_done);
            m3 <= mdl_step(m3, 3, queue_valid, grant_ready, pkt_done);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("m1.grant_valid", int'(gv1), int'(m1.phase == 1));
        chk("m1.busy",        int'(by1), int'(m1.phase == 2));
        chk("m1.grant_index", int'(gi1), m1.idx);
        chk("m3.grant_valid", int'(gv3), int'(m3.phase == 1));
        chk("m3.busy",        int'(by3), int'(m3.phase == 2));
        chk("m3.grant_index", int'(gi3), m3.idx);
    end

    // ---------------- directed helpers ----------------
    function automatic logic gv_of(input int sel);
        return (sel == 3) ? gv3 : gv1;
    endfunction
    function automatic logic by_of(input int sel);
        return (sel == 3) ? by3 : by1;
    endfunction
    function automatic int gi_of(input int sel);
        return (sel == 3) ? int'(gi3) : int'(gi1);
    endfunction

    // Reset both instances with the given inputs applied; release on a negedge.
    task automatic do_reset(input logic [QC-1:0] qv, input logic rdy);
        @(negedge clk);
        #2 rst_n = 1'b0;
        pkt_done    = 1'b0;
        queue_valid = qv;
        grant_ready = rdy;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One served packet with grant_ready held high: wait for the offer,
    // check the queue, see acceptance, pulse pkt_done two cycles after the
    // accepting edge (optionally changing queue_valid with it), then check
    // whether the turn continued (no bubble) or ended.
    task automatic serve(input int sel, input int exp_idx, input logic [QC-1:0] qv_after,
                         input bit cont);
        int n = 0;
        while (!gv_of(sel) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("dut%0d grant offered (q%0d)", sel, exp_idx), int'(gv_of(sel)), 1);
        chk($sformatf("dut%0d grant_index", sel), gi_of(sel), exp_idx);
        @(negedge clk);
        chk($sformatf("dut%0d busy after accept", sel), int'(by_of(sel)), 1);
        chk($sformatf("dut%0d grant_valid after accept", sel), int'(gv_of(sel)), 0);
        @(negedge clk);
        pkt_done    = 1'b1;
        queue_valid = qv_after;
        @(negedge clk);
        pkt_done = 1'b0;
        chk($sformatf("dut%0d busy after done", sel), int'(by_of(sel)), 0);
        chk($sformatf("dut%0d burst continues", sel), int'(gv_of(sel)), int'(cont));
        if (cont) chk($sformatf("dut%0d burst index held", sel), gi_of(sel), exp_idx);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n       = 1'b1;
        queue_valid = '0;
        grant_ready = 1'b0;
        pkt_done    = 1'b0;
        #1 rst_n = 1'b0;

        // Reset state, then all queues valid: grant appears 1 cycle after release.
        @(negedge clk);
        chk("reset grant_valid", int'(gv1), 0);
        chk("reset busy",        int'(by1), 0);
        chk("reset grant_index", int'(gi1), 0);
        queue_valid = 3'b111;
        grant_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("grant 1 cycle after release", int'(gv1), 1);

        // Plain rotation, then shrinking valid sets.
        serve(1, 0, 3'b111, 1'b0);
        serve(1, 1, 3'b111, 1'b0);
        serve(1, 2, 3'b111, 1'b0);
        serve(1, 0, 3'b111, 1'b0);
        serve(1, 1, 3'b011, 1'b0);
        serve(1, 0, 3'b011, 1'b0);
        serve(1, 1, 3'b010, 1'b0);
        serve(1, 1, 3'b010, 1'b0);
        serve(1, 1, 3'b010, 1'b0);

        // Bursts of three on the BURST=3 instance, including an early drain.
        do_reset(3'b101, 1'b1);
        serve(3, 0, 3'b101, 1'b1);
        serve(3, 0, 3'b101, 1'b1);
        serve(3, 0, 3'b101, 1'b0);
        serve(3, 2, 3'b101, 1'b1);
        serve(3, 2, 3'b101, 1'b1);
        serve(3, 2, 3'b101, 1'b0);
        serve(3, 0, 3'b101, 1'b1);
        serve(3, 0, 3'b100, 1'b0);
        serve(3, 2, 3'b100, 1'b1);

        // Withdrawal: queue 2 drains in the same cycle its offer is accepted.
        do_reset(3'b001, 1'b1);
        serve(1, 0, 3'b101, 1'b0);
        grant_ready = 1'b0;
        @(negedge clk);
        chk("offer q2 valid", int'(gv1), 1);
        chk("offer q2 index", int'(gi1), 2);
        @(negedge clk);
        chk("offer q2 held", int'(gi1), 2);
        grant_ready = 1'b1;
        queue_valid = 3'b011;
        @(negedge clk);
        chk("withdraw grant_valid", int'(gv1), 0);
        chk("withdraw busy",        int'(by1), 0);
        @(negedge clk);
        chk("after withdraw index", int'(gi1), 1);
        serve(1, 1, 3'b000, 1'b0);

        // Stray pkt_done in IDLE and in OFFER.
        @(negedge clk);
        pkt_done = 1'b1;
        @(negedge clk);
        pkt_done = 1'b0;
        chk("stray idle grant_valid", int'(gv1), 0);
        chk("stray idle busy",        int'(by1), 0);
        grant_ready = 1'b0;
        queue_valid = 3'b100;
        @(negedge clk);
        chk("offer before stray", int'(gi1), 2);
        pkt_done = 1'b1;
        @(negedge clk);
        pkt_done = 1'b0;
        chk("stray offer grant_valid", int'(gv1), 1);
        chk("stray offer busy",        int'(by1), 0);
        grant_ready = 1'b1;
        @(negedge clk);
        chk("busy before reset", int'(by1), 1);

        // Reset mid-packet clears outputs without waiting for a clock edge.
        #2 rst_n = 1'b0;
        #1;
        chk("async reset busy",        int'(by1), 0);
        chk("async reset grant_valid", int'(gv1), 0);
        chk("async reset dut3 busy",   int'(by3), 0);
        queue_valid = 3'b111;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("first grant after reset", int'(gi1), 0);
        chk("first grant valid",       int'(gv1), 1);

        // Random traffic checked by the model every cycle.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) queue_valid = QC'($urandom);
            grant_ready = ($urandom_range(0, 3) != 0);
            pkt_done    = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 499) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
